risc_cunit: RTL and testbench
=============================

Name: risc_cunit

Overview:
- Multi-cycle control unit that sequences the RISC instruction unit and datapath through FETCH/DECODE/EXEC/WB.
- Consumes the 13-bit IR from the instruction unit.
- Drives the IR load and PC increment strobes, register-file addresses and write enable, and the ALU opcode.
- Handles NOP, HALT, illegal-opcode trap, run/stop control and a retired-instruction counter.

Parameters:
- IW, 13, instruction width; opcode is ir[12:9], rd is ir[8:6], rs1 is ir[5:3], rs2 is ir[2:0].
- RAW, 3, register address width (8 registers).
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  level; 1 allows instruction sequencing.
- mem_ready  in  1  instruction memory data valid for current pc.
- clr_err  in  1  pulse; leaves ERROR state.
- ir  in  IW  instruction register contents from the instruction unit.
- ir_ld  out  1  one-cycle strobe; instruction unit loads ir from memory.
- pc_inc  out  1  one-cycle strobe; pc advances by 1.
- alu_op  out  4  opcode presented to the ALU.
- rf_ra  out  RAW  read port A address (rs1).
- rf_rb  out  RAW  read port B address (rs2, or 0 for unary ops).
- rf_wa  out  RAW  write address (rd).
- rf_we  out  1  register-file write enable.
- busy  out  1  high in FETCH, DECODE, EXEC and WB.
- halted  out  1  high in HALTED.
- err  out  1  high in ERROR.
- retired  out  CNT_W  count of completed instructions, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All strobes 0; alu_op, rf_ra, rf_rb, rf_wa = 0; busy, halted, err = 0; retired = 0.
  - Reset mid-instruction abandons it and performs no write.
- Registered outputs: all outputs are registered and decoded from state plus latched fields.
- IDLE: run=1 moves to FETCH next cycle.
- FETCH:
  - Waits while mem_ready=0 (stall, no strobes).
  - When mem_ready=1: assert ir_ld and pc_inc for exactly one cycle, then go to DECODE.
- DECODE (1 cycle): latch opcode, rd, rs1 and rs2 from ir.
  - Opcode 0 (NOP): retired+1, then go to FETCH if run=1, else IDLE. No EXEC or WB.
  - Opcode 14 (HALT): retired+1, then go to HALTED.
  - Opcode 15 (illegal): go to ERROR. retired unchanged.
  - Opcodes 1–13: go to EXEC.
- EXEC (1 cycle):
  - alu_op = latched opcode; rf_ra = rs1.
  - rf_rb = rs2 for binary ops 1–5 (add, sub, and, or, xor).
  - rf_rb = 0 for unary ops 6–13 (inc, dec, not, neg, shr, shl, ror, rol).
  - Then go to WB.
- WB (1 cycle):
  - rf_we = 1, rf_wa = rd; alu_op, rf_ra and rf_rb hold their EXEC values.
  - retired+1.
  - Then go to FETCH if run=1, else IDLE.
- Latency with mem_ready held high:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - NOP or HALT: 2 cycles.
  - Back-to-back ALU ops: one ir_ld every 4 cycles.
- run deasserted mid-instruction: the current instruction completes including WB; sequencing stops at the next FETCH decision. run=0 while stalled in FETCH returns to IDLE with no strobes.
- HALTED: holds halted=1 while run=1; run=0 returns to IDLE. A later run=1 resumes at the current pc.
- ERROR:
  - err=1 sticky; no strobes or writes; run is ignored.
  - clr_err=1 returns to IDLE.
  - pc has already advanced past the illegal word.
- retired saturates at all-ones and does not wrap.
- Simultaneous run=0 and mem_ready=1 in FETCH: run has priority; go to IDLE with no ir_ld or pc_inc.
- rf_we is never asserted outside WB. ir_ld and pc_inc are always coincident.

Test Plan:
- Reset, run=1, mem_ready=1, ir=13'h0208 (add rd=0, rs1=1, rs2=0) → ir_ld/pc_inc at cycle 1, then EXEC with alu_op=1, rf_ra=1, rf_rb=0; then WB with rf_we=1, rf_wa=0; retired=1 after 4 cycles.
- Sequence 13'h05f1, 13'h0d45, 13'h1b04 → alu_op 2, 6, 13 in successive EXECs; rf_wa 7, 5, 4; rf_rb 1, 0, 0 (unary forced 0); retired=3 after 12 cycles.
- mem_ready=0 for 5 cycles in FETCH → no ir_ld, busy=1; mem_ready=1 → single ir_ld/pc_inc pulse.
- ir=13'h1C00 (HALT) → halted=1, retired+1, no rf_we. Drop run → IDLE. Raise run → FETCH.
- ir=13'h1E00 (opcode 15) → err=1, no rf_we, run ignored for 10 cycles; clr_err pulse → IDLE, err=0.
- Assert rst_n=0 during EXEC → outputs zero immediately with no WB write; run=0 during DECODE of an add → WB still writes, then IDLE.

Source files
------------

// File: rtl/risc_cunit.sv
// risc_cunit: multi-cycle FETCH/DECODE/EXEC/WB sequencer for the RISC core.
// Every output is a flop whose next value is derived from the next state and
// the fields captured during DECODE, so outputs line up with the state they
// describe. ir is sampled when DECODE exits. The instruction unit presents the
// freshly loaded word while ir_ld is high, which is the DECODE cycle.
module risc_cunit #(
    parameter int IW    = 13,
    parameter int RAW   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             mem_ready,
    input  logic             clr_err,
    input  logic [IW-1:0]    ir,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic [3:0]       alu_op,
    output logic [RAW-1:0]   rf_ra,
    output logic [RAW-1:0]   rf_rb,
    output logic [RAW-1:0]   rf_wa,
    output logic             rf_we,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_LAST_BIN = 4'd5;
    localparam logic [3:0] OP_HALT     = 4'd14;
    localparam logic [3:0] OP_ILL      = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [RAW-1:0]   rd_q, rd_d;
    logic             ir_ld_q, ir_ld_d;
    logic             pc_inc_q, pc_inc_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [RAW-1:0]   rf_ra_q, rf_ra_d;
    logic [RAW-1:0]   rf_rb_q, rf_rb_d;
    logic [RAW-1:0]   rf_wa_q, rf_wa_d;
    logic             rf_we_q, rf_we_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    logic [3:0]     ir_op;
    logic [RAW-1:0] ir_rd, ir_rs1, ir_rs2;

    assign ir_op  = ir[IW-1 -: 4];
    assign ir_rd  = ir[3*RAW-1 -: RAW];
    assign ir_rs1 = ir[2*RAW-1 -: RAW];
    assign ir_rs2 = ir[RAW-1:0];

    // Next-state and next-output decode; datapath controls hold unless updated.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        ir_ld_d  = 1'b0;
        pc_inc_d = 1'b0;
        alu_op_d = alu_op_q;
        rf_ra_d  = rf_ra_q;
        rf_rb_d  = rf_rb_q;
        rf_wa_d  = rf_wa_q;
        rf_we_d  = 1'b0;
        retire   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                // run wins over mem_ready so a stop never loads a new word
                if (!run) begin
                    state_d = S_IDLE;
                end else if (mem_ready) begin
                    state_d  = S_DECODE;
                    ir_ld_d  = 1'b1;
                    pc_inc_d = 1'b1;
                end
            end
            S_DECODE: begin
                rd_d = ir_rd;
                if (ir_op == OP_NOP) begin
                    retire  = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end else if (ir_op == OP_HALT) begin
                    retire  = 1'b1;
                    state_d = S_HALTED;
                end else if (ir_op == OP_ILL) begin
                    state_d = S_ERROR;
                end else begin
                    state_d  = S_EXEC;
                    alu_op_d = ir_op;
                    rf_ra_d  = ir_rs1;
                    rf_rb_d  = (ir_op <= OP_LAST_BIN) ? ir_rs2 : '0;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                rf_we_d = 1'b1;
                rf_wa_d = rd_q;
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALTED: begin
                if (!run) state_d = S_IDLE;
            end
            S_ERROR: begin
                if (clr_err) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        retired_d = (retire && (retired_q != '1)) ? retired_q + 1'b1 : retired_q;
        busy_d    = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                    (state_d == S_EXEC)  || (state_d == S_WB);
        halted_d  = (state_d == S_HALTED);
        err_d     = (state_d == S_ERROR);
    end

    // State and registered outputs; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_q      <= '0;
            ir_ld_q   <= 1'b0;
            pc_inc_q  <= 1'b0;
            alu_op_q  <= '0;
            rf_ra_q   <= '0;
            rf_rb_q   <= '0;
            rf_wa_q   <= '0;
            rf_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            ir_ld_q   <= ir_ld_d;
            pc_inc_q  <= pc_inc_d;
            alu_op_q  <= alu_op_d;
            rf_ra_q   <= rf_ra_d;
            rf_rb_q   <= rf_rb_d;
            rf_wa_q   <= rf_wa_d;
            rf_we_q   <= rf_we_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    assign ir_ld   = ir_ld_q;
    assign pc_inc  = pc_inc_q;
    assign alu_op  = alu_op_q;
    assign rf_ra   = rf_ra_q;
    assign rf_rb   = rf_rb_q;
    assign rf_wa   = rf_wa_q;
    assign rf_we   = rf_we_q;
    assign busy    = busy_q;
    assign halted  = halted_q;
    assign err     = err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_risc_cunit.sv
// Bench for risc_cunit: the instruction unit is modelled by a program queue
// that supplies a new ir word on each ir_ld. Per-instruction effects are
// pushed to a scoreboard, and a monitor pops an entry on each rf_we.
module tb_risc_cunit;

    localparam int CW = 5;
    localparam int unsigned RMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, run, mem_ready, clr_err;
    logic [12:0]   ir;
    logic          ir_ld, pc_inc, rf_we, busy, halted, err;
    logic [3:0]    alu_op;
    logic [2:0]    rf_ra, rf_rb, rf_wa;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    risc_cunit #(.IW(13), .RAW(3), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mem_ready(mem_ready),
        .clr_err(clr_err), .ir(ir), .ir_ld(ir_ld), .pc_inc(pc_inc),
        .alu_op(alu_op), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa),
        .rf_we(rf_we), .busy(busy), .halted(halted), .err(err),
        .retired(retired)
    );

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd, ra, rb;
        int unsigned ret;
        int unsigned due;
    } wb_t;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned model_ret = 0;
    logic [12:0] prog[$];
    wb_t         exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int unsigned sat(input int unsigned n);
        return (n > RMAX) ? RMAX : n;
    endfunction

    // Reference: effect of one fetched word, from the opcode rules alone
    task automatic model_fetch(input logic [12:0] w, input int unsigned t);
        logic [3:0] op;
        wb_t e;
        op = w[12:9];
        if (op >= 4'd1 && op <= 4'd13) begin
            e.op  = op;
            e.rd  = w[8:6];
            e.ra  = w[5:3];
            e.rb  = (op <= 4'd5) ? w[2:0] : 3'd0;
            e.ret = sat(model_ret);
            e.due = t + 2;
            exp_q.push_back(e);
            model_ret++;
        end else if (op == 4'd0 || op == 4'd14) begin
            model_ret++;
        end
    endtask

    // Monitor: strobe invariants and writeback scoreboard
    logic       prev_ld = 1'b0, prev_we = 1'b0;
    logic [3:0] prev_op = '0;
    logic [2:0] prev_ra = '0, prev_rb = '0;
    always @(negedge clk) begin : mon
        wb_t e;
        if (rst_n) begin
            if (ir_ld || pc_inc) chk("strobe_pair", 32'(pc_inc), 32'(ir_ld));
            if (ir_ld) chk("ir_ld_width", 32'(prev_ld), 0);
            if (rf_we) begin
                chk("we_state", 32'({busy, halted, err}), 32'b100);
                chk("we_width", 32'(prev_we), 0);
                chk("we_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wb_alu_op", 32'(alu_op), 32'(e.op));
                    chk("wb_rf_ra", 32'(rf_ra), 32'(e.ra));
                    chk("wb_rf_rb", 32'(rf_rb), 32'(e.rb));
                    chk("wb_rf_wa", 32'(rf_wa), 32'(e.rd));
                    chk("exec_alu_op", 32'(prev_op), 32'(e.op));
                    chk("exec_rf_ra", 32'(prev_ra), 32'(e.ra));
                    chk("exec_rf_rb", 32'(prev_rb), 32'(e.rb));
                    chk("wb_retired", 32'(retired), e.ret);
                    chk("wb_cycle", cyc, e.due);
                end
            end
        end
        prev_ld <= ir_ld;
        prev_we <= rf_we;
        prev_op <= alu_op;
        prev_ra <= rf_ra;
        prev_rb <= rf_rb;
    end

    // Runs the queued program; first_lat!=0 checks cycles from run to first ir_ld
    task automatic run_prog(input bit keep_run, input int unsigned stall_pct,
                            input int unsigned first_lat);
        int unsigned start, last_ld;
        int          last_op;
        bit          done;
        logic [12:0] w;
        start     = cyc;
        last_ld   = 0;
        last_op   = -1;
        done      = 1'b0;
        run       = 1'b1;
        mem_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (ir_ld) begin
                chk("fetch_expected", 32'(prog.size() != 0), 1);
                if (prog.size() != 0) begin
                    w = prog.pop_front();
                    if (last_op < 0 && first_lat != 0) chk("first_fetch_lat", cyc - start, first_lat);
                    if (stall_pct == 0 && last_op >= 0) chk("issue_gap", cyc - last_ld, (last_op == 0) ? 2 : 4);
                    last_ld = cyc;
                    last_op = int'(w[12:9]);
                    ir = w;
                    model_fetch(w, cyc);
                    if (prog.size() == 0 && !keep_run) run = 1'b0;
                end
            end
            mem_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
            done = (prog.size() == 0) && !busy && (err || (keep_run ? halted : !halted));
        end
        chk("prog_done", 32'(done), 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_retired"}, 32'(retired), sat(model_ret));
    endtask

    initial begin
        logic [12:0] w;
        int unsigned len;
        int unsigned ret_snap;
        bit          seen;
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; clr_err = 1'b0; ir = '0;
        repeat (2) @(negedge clk);
        chk("rst_ir_ld", 32'(ir_ld), 0);
        chk("rst_pc_inc", 32'(pc_inc), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_rf_addrs", 32'({rf_ra, rf_rb, rf_wa}), 0);
        chk("rst_flags", 32'({rf_we, busy, halted, err}), 0);
        chk("rst_retired", 32'(retired), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single add, then a binary/unary mix
        prog.push_back(13'h0208);
        run_prog(1'b0, 0, 2);
        check_idle("t1");
        prog.push_back(13'h05f1); prog.push_back(13'h0d45); prog.push_back(13'h1b04);
        run_prog(1'b0, 0, 2);
        check_idle("t2");

        // Fetch stall: five cycles without mem_ready, then a single load
        prog.push_back(13'h0a53);
        mem_ready = 1'b0; run = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_no_ld", 32'(ir_ld), 0);
            chk("stall_busy", 32'(busy), 1);
            @(negedge clk);
        end
        run_prog(1'b0, 0, 1);
        check_idle("t3");

        // Stop while stalled, with run=0 and mem_ready=1 together
        mem_ready = 1'b0; run = 1'b1;
        @(negedge clk);
        chk("stop_stall_busy", 32'(busy), 1);
        run = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("stop_no_ld", 32'(ir_ld), 0);
        chk("stop_idle", 32'(busy), 0);
        mem_ready = 1'b0;
        @(negedge clk);

        // HALT: holds while run=1, drops to IDLE on run=0, then resumes
        prog.push_back(13'h1C00);
        run_prog(1'b1, 0, 2);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_retired", 32'(retired), sat(model_ret));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_hold", 32'({halted, busy, ir_ld}), 32'b100);
        end
        run = 1'b0;
        @(negedge clk);
        chk("halt_release", 32'({halted, busy}), 0);
        prog.push_back(13'h0c9a);
        run_prog(1'b0, 0, 2);
        check_idle("t4");

        // Illegal opcode: sticky err, run ignored, clr_err recovers
        ret_snap = model_ret;
        prog.push_back(13'h1E00);
        run_prog(1'b1, 0, 2);
        for (int i = 0; i < 10; i++) begin
            run = 1'($urandom);
            @(negedge clk);
            chk("err_sticky", 32'({err, busy, ir_ld}), 32'b100);
        end
        run = 1'b0; clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("err_cleared", 32'({err, busy, halted}), 0);
        chk("err_retired", 32'(retired), sat(ret_snap));

        // Reset during EXEC abandons the instruction with no write
        mem_ready = 1'b1; run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = ir_ld;
        end
        chk("rst_test_fetch", 32'(seen), 1);
        ir = 13'h0d45;
        @(negedge clk);
        chk("rst_test_exec_op", 32'(alu_op), 6);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_outs", 32'({alu_op, rf_ra, rf_rb, rf_wa, rf_we, busy, ir_ld}), 0);
        chk("rst_async_retired", 32'(retired), 0);
        run = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_no_we", 32'(rf_we), 0);
        rst_n = 1'b1;
        model_ret = 0;
        @(negedge clk);
        chk("rst_no_we_after", 32'({rf_we, busy}), 0);

        // Randomized programs, with and without fetch stalls; drives retired into saturation
        for (int p = 0; p < 16; p++) begin
            len = $urandom_range(2, 6);
            for (int k = 0; k < int'(len); k++) begin
                w = 13'($urandom);
                w[12:9] = 4'($urandom_range(0, 13));
                prog.push_back(w);
            end
            if (p % 2 == 1) run_prog(1'b0, 30, 0);
            else            run_prog(1'b0, 0, 2);
            check_idle("rand");
        end
        chk("retired_saturated", 32'(retired), RMAX);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
